// File: rtl/sprite_pkg.sv
// sprite_pkg: shared constants, row record and pixel-select helper for the
// sprite row serializer.
//   PIX_W        bits per pixel
//   PIX_PER_ROW  pixels in one accepted row
//   ADDR_W       line-buffer address width (addresses wrap modulo 2^ADDR_W)
//   row_t        one queued row: packed pixels, start address, flip flag
//   sel_pixel    returns pixel k of a row, taking horizontal flip into account
package sprite_pkg;

    localparam int PIX_W       = 4;
    localparam int PIX_PER_ROW = 8;
    localparam int ADDR_W      = 8;
    localparam int ROW_W       = PIX_W * PIX_PER_ROW;
    localparam int K_W         = $clog2(PIX_PER_ROW);

    typedef logic [PIX_W-1:0]  pix_t;
    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [K_W-1:0]    k_t;

    localparam k_t K_LAST = k_t'(PIX_PER_ROW - 1);

    typedef struct packed {
        logic [ROW_W-1:0] data;   // pixel 0 in the MSBs
        addr_t            x;      // line-buffer address of pixel 0
        logic             flip;
    } row_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    // Pixel 0 sits in the top nibble, so the unflipped walk goes from the
    // MSB end down; a flipped row walks up from the LSB end instead.
    function automatic pix_t sel_pixel(input row_t row, input k_t k);
        int slot;
        slot = row.flip ? int'(k) : (PIX_PER_ROW - 1 - int'(k));
        return pix_t'(row.data >> (slot * PIX_W));
    endfunction

endpackage

// File: rtl/sprite_row_serializer_if.sv
// sprite_row_serializer_if: row input handshake plus pixel write bus.
//   in_valid/in_ready/in_data/in_x/in_flip  row feed (master -> serializer)
//   out_pix/out_addr/out_we                 line-buffer write port
//   busy                                    a row is shifting or queued
// master = row feeder / bus observer, slave = serializer.
interface sprite_row_serializer_if;
    import sprite_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [ROW_W-1:0] in_data;
    addr_t            in_x;
    logic             in_flip;
    pix_t             out_pix;
    addr_t            out_addr;
    logic             out_we;
    logic             busy;

    modport master (
        output in_valid, in_data, in_x, in_flip,
        input  in_ready, out_pix, out_addr, out_we, busy
    );

    modport slave (
        input  in_valid, in_data, in_x, in_flip,
        output in_ready, out_pix, out_addr, out_we, busy
    );

endinterface

// File: rtl/row_slot_queue.sv
// row_slot_queue: two-entry row holder. CUR is the row being shifted, NXT is
// the row waiting behind it.
//   clk, reset     system clock, synchronous active-high reset
//   flush_i        empties both slots (wins over push/pop)
//   push_i         store push_row_i; lands in CUR if CUR is empty after this
//                  clk's pop, else in NXT (caller only pushes when NXT is free)
//   pop_i          CUR finished; NXT (if any) becomes CUR
//   cur_valid_o, cur_row_o, nxt_valid_o  slot status
module row_slot_queue
    import sprite_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic flush_i,
    input  logic push_i,
    input  row_t push_row_i,
    input  logic pop_i,
    output logic cur_valid_o,
    output row_t cur_row_o,
    output logic nxt_valid_o
);

    logic cur_valid_q, cur_valid_d;
    logic nxt_valid_q, nxt_valid_d;
    row_t cur_row_q, cur_row_d;
    row_t nxt_row_q, nxt_row_d;

    always_comb begin
        cur_valid_d = cur_valid_q;
        cur_row_d   = cur_row_q;
        nxt_valid_d = nxt_valid_q;
        nxt_row_d   = nxt_row_q;
        if (pop_i) begin
            cur_valid_d = nxt_valid_q;
            cur_row_d   = nxt_row_q;
            nxt_valid_d = 1'b0;
        end
        // Placement looks at CUR after the pop so a row pushed on the last
        // pixel of an unqueued row goes straight into CUR.
        if (push_i) begin
            if (!cur_valid_d) begin
                cur_valid_d = 1'b1;
                cur_row_d   = push_row_i;
            end else begin
                nxt_valid_d = 1'b1;
                nxt_row_d   = push_row_i;
            end
        end
        if (flush_i) begin
            cur_valid_d = 1'b0;
            nxt_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_valid_q <= 1'b0;
            nxt_valid_q <= 1'b0;
            cur_row_q   <= '0;
            nxt_row_q   <= '0;
        end else begin
            cur_valid_q <= cur_valid_d;
            nxt_valid_q <= nxt_valid_d;
            cur_row_q   <= cur_row_d;
            nxt_row_q   <= nxt_row_d;
        end
    end

    assign cur_valid_o = cur_valid_q;
    assign cur_row_o   = cur_row_q;
    assign nxt_valid_o = nxt_valid_q;

endmodule

// File: rtl/sprite_row_serializer.sv
// sprite_row_serializer: takes packed sprite rows and writes them into the
// 4-bit line buffer one pixel per pix_ce, skipping transparent (0) pixels.
//   clk, reset   system clock, synchronous active-high reset
//   pix_ce       pixel-rate enable, one clk wide
//   line_start   line-boundary flush: drops all rows, blocks acceptance
//   bus          row feed and write port (slave side)
module sprite_row_serializer
    import sprite_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    pix_ce,
    input  logic                    line_start,
    sprite_row_serializer_if.slave  bus
);

    state_e state_q, state_d;
    k_t     k_q, k_d;
    pix_t   out_pix_q, out_pix_d;
    addr_t  out_addr_q, out_addr_d;
    logic   out_we_q, out_we_d;

    logic   cur_valid, nxt_valid;
    row_t   cur_row, in_row;
    pix_t   cur_pix;
    logic   in_ready, accept, emit, row_end;

    // No look-ahead: NXT emptying this clk does not open the slot until the
    // following clk.
    assign in_ready = !nxt_valid && !line_start && !reset;
    assign accept   = bus.in_valid && in_ready;
    assign emit     = (state_q == ST_SHIFT) && pix_ce && !line_start;
    assign row_end  = emit && (k_q == K_LAST);
    assign cur_pix  = sel_pixel(cur_row, k_q);

    assign in_row.data = bus.in_data;
    assign in_row.x    = bus.in_x;
    assign in_row.flip = bus.in_flip;

    row_slot_queue u_slots (
        .clk         (clk),
        .reset       (reset),
        .flush_i     (line_start),
        .push_i      (accept),
        .push_row_i  (in_row),
        .pop_i       (row_end),
        .cur_valid_o (cur_valid),
        .cur_row_o   (cur_row),
        .nxt_valid_o (nxt_valid)
    );

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            k_q        <= '0;
            out_pix_q  <= '0;
            out_addr_q <= '0;
            out_we_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            out_pix_q  <= out_pix_d;
            out_addr_q <= out_addr_d;
            out_we_q   <= out_we_d;
        end
    end

    // Next state: SHIFT exactly while CUR holds a row.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = ST_SHIFT;
            // A push on the final pixel with NXT empty refills CUR directly.
            ST_SHIFT: if (row_end && !nxt_valid && !accept) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (line_start) state_d = ST_IDLE;
    end

    // Outputs and pixel index. k returns to 0 at every row end so a promoted
    // row starts at its pixel 0 on the very next pix_ce.
    always_comb begin
        k_d        = k_q;
        out_pix_d  = out_pix_q;
        out_addr_d = out_addr_q;
        out_we_d   = 1'b0;
        if (emit) begin
            out_pix_d  = cur_pix;
            out_addr_d = cur_row.x + addr_t'(k_q);
            out_we_d   = (cur_pix != '0);
            k_d        = row_end ? '0 : k_q + k_t'(1);
        end
        if (line_start) k_d = '0;
    end

    assign bus.in_ready = in_ready;
    assign bus.out_pix  = out_pix_q;
    assign bus.out_addr = out_addr_q;
    assign bus.out_we   = out_we_q;
    assign bus.busy     = cur_valid || nxt_valid;

endmodule
